// File: rtl/edge_pulse_bank_if.sv
// edge_pulse_bank_if
//  Groups the per-channel signals of edge_pulse_bank. Names are from the
//  bank's point of view: i_* enter the bank, o_* leave it.
//  i_level        CHANNELS     raw async input levels
//  i_mode         2*CHANNELS   edge select, ch i = i_mode[2i+1:2i]
//                              (00 off, 01 rise, 10 fall, 11 both)
//  i_evt_clr      CHANNELS     sticky-flag clear
//  o_pulse        CHANNELS     registered, stretched edge pulse
//  o_level_clean  CHANNELS     synchronised, debounced level
//  o_evt_flag     CHANNELS     sticky "edge seen"
//  o_any_pulse    1            OR of o_pulse, same cycle as o_pulse
//  master: the side that drives levels/modes; slave: the bank itself.
interface edge_pulse_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   i_level;
  logic [2*CHANNELS-1:0] i_mode;
  logic [CHANNELS-1:0]   i_evt_clr;
  logic [CHANNELS-1:0]   o_pulse;
  logic [CHANNELS-1:0]   o_level_clean;
  logic [CHANNELS-1:0]   o_evt_flag;
  logic                  o_any_pulse;

  modport master (
    output i_level, i_mode, i_evt_clr,
    input  o_pulse, o_level_clean, o_evt_flag, o_any_pulse
  );

  modport slave (
    input  i_level, i_mode, i_evt_clr,
    output o_pulse, o_level_clean, o_evt_flag, o_any_pulse
  );
endinterface

// File: rtl/edge_pulse_bank.sv
// edge_pulse_bank
//  Multi-channel level-to-pulse converter. Each channel synchronises an async
//  level, debounces it, detects the selected edge(s), stretches the result to
//  a PULSE_LEN-cycle pulse and keeps a sticky event flag.
//  Ports:
//   i_clk  system clock, rising edge
//   i_rst  async reset, active-high; clears every flop immediately
//   bus    edge_pulse_bank_if.slave (levels, modes, clears in; pulses,
//          clean levels, flags, any_pulse out)

// One channel. o_next_pulse is the D input of the pulse flop, exported so the
// bank can register an OR that lines up with o_pulse.
module edge_pulse_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int PULSE_LEN       = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_level,
  input  logic [1:0] i_mode,
  input  logic       i_evt_clr,
  output logic       o_pulse,
  output logic       o_next_pulse,
  output logic       o_level_clean,
  output logic       o_evt_flag
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(PULSE_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_clean;
  logic                   r_prev;
  logic [SW-1:0]          r_st;
  logic                   r_pulse;
  logic                   r_evt;

  logic          w_s;
  logic          w_rise;
  logic          w_fall;
  logic          w_qual;
  logic [SW-1:0] w_next_st;
  logic          w_next_pulse;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser chain; bit 0 is the only flop that sees the raw level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_level};
  end

  // Debounce: the counter only runs while the synchronised level disagrees
  // with the accepted one, so any return to the old level restarts it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else if (w_s == r_clean) begin
      r_cnt   <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_clean <= w_s;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Edges come from the clean level only, so changing i_mode cannot fake one.
  assign w_rise = r_clean & ~r_prev;
  assign w_fall = ~r_clean & r_prev;

  always_comb begin
    w_qual = 1'b0;
    case (i_mode)
      2'b01:   w_qual = w_rise;
      2'b10:   w_qual = w_fall;
      2'b11:   w_qual = w_rise | w_fall;
      default: w_qual = 1'b0;
    endcase
  end

  // Stretch: a qualified edge (re)loads the counter, so a retrigger during a
  // pulse extends it without a gap; mode 00 still lets a running pulse drain.
  always_comb begin
    w_next_st    = r_st;
    w_next_pulse = 1'b0;
    if (w_qual) begin
      w_next_st    = SW'(PULSE_LEN - 1);
      w_next_pulse = 1'b1;
    end else if (r_st != '0) begin
      w_next_st    = r_st - SW'(1);
      w_next_pulse = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev  <= 1'b0;
      r_st    <= '0;
      r_pulse <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_prev  <= r_clean;
      r_st    <= w_next_st;
      r_pulse <= w_next_pulse;
      // A new pulse beats a simultaneous clear.
      if (w_next_pulse && !r_pulse) r_evt <= 1'b1;
      else if (i_evt_clr)           r_evt <= 1'b0;
    end
  end

  assign o_pulse       = r_pulse;
  assign o_next_pulse  = w_next_pulse;
  assign o_level_clean = r_clean;
  assign o_evt_flag    = r_evt;
endmodule

module edge_pulse_bank #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int PULSE_LEN       = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  edge_pulse_bank_if.slave   bus
);
  logic [CHANNELS-1:0] w_pulse;
  logic [CHANNELS-1:0] w_next_pulse;
  logic [CHANNELS-1:0] w_clean;
  logic [CHANNELS-1:0] w_evt;
  logic                r_any;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    edge_pulse_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_LEN      (PULSE_LEN)
    ) u_lane (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_level      (bus.i_level[g]),
      .i_mode       (bus.i_mode[2*g +: 2]),
      .i_evt_clr    (bus.i_evt_clr[g]),
      .o_pulse      (w_pulse[g]),
      .o_next_pulse (w_next_pulse[g]),
      .o_level_clean(w_clean[g]),
      .o_evt_flag   (w_evt[g])
    );
  end

  // Registered from the pulse flops' D inputs so it rises/falls with o_pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_any <= 1'b0;
    else       r_any <= |w_next_pulse;
  end

  assign bus.o_pulse       = w_pulse;
  assign bus.o_level_clean = w_clean;
  assign bus.o_evt_flag    = w_evt;
  assign bus.o_any_pulse   = r_any;
endmodule
